// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// remainder on hi_o and quotient on lo_o, written together under a one-cycle valid_o pulse.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // state | meaning
  // IDLE  | waiting for start_i; also the cycle in which valid_o pulses
  // ZERO  | divisor was zero, result preloaded, one filler cycle
  // RUN   | one restoring iteration per cycle, MSB first
  // DONE  | load hi_o/lo_o with sign fixup, pulse valid_o next cycle
  typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             q_neg, r_neg, valid_r;

  logic             a_neg, b_neg, borrow;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;

  assign a_neg = signed_i & a_i[WIDTH-1];
  assign b_neg = signed_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // shifted < 2*dvs always, so bit WIDTH of the difference is exactly the borrow
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign borrow  = diff[WIDTH];

  assign valid_o = valid_r & ~cancel_i;
  assign busy_o  = (state != IDLE) | valid_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_i) state_nx = (b_i == '0) ? ZERO : RUN;
      ZERO: state_nx = DONE;
      RUN:  if (count == CW'(WIDTH - 1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (cancel_i) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      valid_r <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !cancel_i) begin
            count <= '0;
            dvs   <= b_mag;
            if (b_i == '0) begin
              // divide-by-zero: raw dividend as remainder, no sign fixup
              rem   <= a_i;
              quo   <= '1;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              rem   <= '0;
              quo   <= a_mag;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
            end
          end
        end
        RUN: begin
          count <= count + 1'b1;
          rem   <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ~borrow};
        end
        DONE: begin
          if (!cancel_i) begin
            valid_r <= 1'b1;
            hi_o    <= r_neg ? -rem : rem;
            lo_o    <= q_neg ? -quo : quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level reference model checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, signed_i = 1'b0, cancel_i = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        busy_o, valid_o;
  logic [31:0] hi_o, lo_o;

  int tests = 0;
  int fails = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .cancel_i(cancel_i), .a_i(a_i), .b_i(b_i), .busy_o(busy_o),
    .valid_o(valid_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    logic [31:0] qu, ru;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    qu = a / b;
    ru = a % b;
    return {ru, qu};
  endfunction

  // Timeline model: an accepted op produces its result pulse a fixed number of cycles later
  int          cyc = 0;
  int          valid_at = 0;
  int          pulse_cyc = -1;
  bit          active = 1'b0;
  logic [31:0] exp_hi = '0, exp_lo = '0, cur_hi = '0, cur_lo = '0;
  bit          ev;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      active    = 1'b0;
      pulse_cyc = -1;
      cur_hi    = '0;
      cur_lo    = '0;
    end else begin
      cyc++;
      if (cancel_i) active = 1'b0;
      else if (start_i && !active) begin
        active   = 1'b1;
        valid_at = cyc + ((b_i == 32'd0) ? 2 : 33);
        {exp_hi, exp_lo} = ref_div(a_i, b_i, signed_i);
      end
      if (active && cyc == valid_at) begin
        active    = 1'b0;
        cur_hi    = exp_hi;
        cur_lo    = exp_lo;
        pulse_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    ev = (cyc == pulse_cyc) && !cancel_i && rst;
    chk("cyc valid_o", {31'd0, valid_o}, {31'd0, ev});
    chk("cyc busy_o", {31'd0, busy_o}, {31'd0, active || ev});
    chk("cyc hi_o", hi_o, cur_hi);
    chk("cyc lo_o", lo_o, cur_lo);
  end

  // Call at posedge+1 with the DUT idle; elat counts edges from the accepting edge.
  task automatic go(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [31:0] eh, input logic [31:0] el, input int elat);
    int n, nbusy;
    bit seen;
    a_i = a; b_i = b; signed_i = s; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    n = -1; nbusy = 0; seen = 1'b0;
    for (int i = 0; i <= 100 && !seen; i++) begin
      @(negedge clk);
      if (busy_o) nbusy++;
      if (valid_o) begin seen = 1'b1; n = i; end
    end
    chk({nm, " latency"}, n, elat);
    chk({nm, " busy cycles"}, nbusy, elat + 1);
    chk({nm, " hi"}, hi_o, eh);
    chk({nm, " lo"}, lo_o, el);
    @(posedge clk); #1;
  endtask

  int pulses, gap1, gap2, last_pulse, spurious;

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("reset busy", {31'd0, busy_o}, 32'd0);
    chk("reset valid", {31'd0, valid_o}, 32'd0);
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    go("u100/7",      32'd100,        32'd7,          1'b0, 32'd2,          32'd14,         33);
    go("s-7/2",       32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  33);
    go("u-7/2",       32'hFFFF_FFF9,  32'd2,          1'b0, 32'd1,          32'h7FFF_FFFC,  33);
    go("s ovf",       32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  33);
    go("u max/1",     32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          32'hFFFF_FFFF,  33);
    go("s 7/-2",      32'd7,          32'hFFFF_FFFE,  1'b1, 32'd1,          32'hFFFF_FFFD,  33);
    go("u 5/9",       32'd5,          32'd9,          1'b0, 32'd5,          32'd0,          33);
    go("div0",        32'h1234,       32'd0,          1'b0, 32'h1234,       32'hFFFF_FFFF,  2);
    go("s div0 neg",  32'hFFFF_FF00,  32'd0,          1'b1, 32'hFFFF_FF00,  32'hFFFF_FFFF,  2);

    // cancel in cycle 10 of a run
    a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 cancel_i = 1'b1;
    @(posedge clk); #1 cancel_i = 1'b0;
    @(negedge clk);
    chk("cancel busy", {31'd0, busy_o}, 32'd0);
    chk("cancel hi kept", hi_o, 32'hFFFF_FF00);
    chk("cancel lo kept", lo_o, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    go("after cancel", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 33);

    // asynchronous reset mid-run
    a_i = 32'd1000; b_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrun rst busy", {31'd0, busy_o}, 32'd0);
    chk("midrun rst valid", {31'd0, valid_o}, 32'd0);
    chk("midrun rst hi", hi_o, 32'd0);
    chk("midrun rst lo", lo_o, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    spurious = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) spurious++;
    end
    chk("no valid after rst", spurious, 32'd0);
    @(posedge clk); #1;

    // start held high: one result every 34 cycles
    a_i = 32'd20; b_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
    pulses = 0; gap1 = 0; gap2 = 0; last_pulse = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (valid_o) begin
        if (pulses == 1) gap1 = i - last_pulse;
        if (pulses == 2) gap2 = i - last_pulse;
        pulses++;
        last_pulse = i;
      end
    end
    #1 start_i = 1'b0;
    chk("held start pulses", pulses, 32'd3);
    chk("held start gap1", gap1, 32'd34);
    chk("held start gap2", gap2, 32'd34);
    chk("held start lo", lo_o, 32'd6);
    chk("held start hi", hi_o, 32'd2);
    repeat (40) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got t=%0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
